// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared types and helpers for the bit-serial subtractor.
//   ss_state_t : controller states (IDLE, RUN, DONE)
//   cnt_width  : bit-counter width, max(1, $clog2(w))
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ss_state_t;

    // A 1-bit operand still needs a 1-bit counter, hence the floor of 1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// Combinational one-bit subtractor cell: computes x - y - bin.
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow-in
//   d    : difference bit
//   bout : borrow-out
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when y beats x outright, or when they tie and a borrow is pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with a valid/ready handshake on input and output.
//   clk       : rising-edge clock
//   rst       : synchronous active-low reset
//   in_valid  : operands a, b, bin presented
//   in_ready  : block can accept operands this cycle
//   a, b      : minuend / subtrahend (WIDTH bits)
//   bin       : borrow-in
//   out_valid : diff/bout/ovf hold a completed result
//   out_ready : downstream accepts the result
//   diff      : a - b - bin modulo 2^WIDTH
//   bout      : borrow-out (unsigned a < b + bin)
//   ovf       : two's-complement signed overflow
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ss_state_t        state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             borrow_q;
    logic             borrow_d;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             d_bit;

    full_subtractor u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (d_bit),
        .bout (borrow_d)
    );

    // New difference bit enters at the MSB; after WIDTH shifts the LSB of the
    // first computed bit has walked down to position 0.
    assign res_d = WIDTH'({d_bit, res_q} >> 1);

    // Controller, borrow, result and captured sign bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            res_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operand shift registers carry pure data and need no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            if (in_valid) begin
                a_sh_q <= a;
                b_sh_q <= b;
            end
        end else if (state_q == RUN) begin
            a_sh_q <= a_sh_q >> 1;
            b_sh_q <= b_sh_q >> 1;
        end
    end

    // in_ready is gated by rst so nothing is accepted while reset is held.
    assign in_ready  = rst && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = res_q;
    assign bout      = borrow_q;
    // Overflow only possible when operand signs differ; then the result must
    // keep the minuend's sign.
    assign ovf       = (a_msb_q ^ b_msb_q) & (res_q[WIDTH-1] ^ a_msb_q);

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor; the arithmetic inverse of the adder family (full_adder / ripple_adder_generic).
- Computes diff = a - b - bin one bit per clock, LSB first, using a single borrow flip-flop.
- Valid/ready handshake on both sides, so it drops into streaming datapaths where area matters more than latency.
- Also reports borrow-out and two's-complement signed overflow.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset; sampled on clk rising edge
- in_valid  input  1  operands a, b, bin presented
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff/bout/ovf hold a completed result
- out_ready  input  1  downstream accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 when unsigned a < b + bin
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-low (rst == 0 at a clk edge resets).
- Reset values: state IDLE; counter 0; borrow FF 0; result shift register 0; diff 0; bout 0; ovf 0; out_valid 0. in_ready is forced 0 while rst == 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - On an edge with in_valid && in_ready: latch a and b into shift registers, borrow FF <= bin, cnt <= 0, capture a[MSB] and b[MSB] for ovf, go to RUN.
- RUN:
  - in_ready = 0 and out_valid = 0.
  - Each edge, on x = a_sh[0], y = b_sh[0], w = borrow:
    - d = x ^ y ^ w
    - borrow <= (~x & y) | (~(x ^ y) & w)
    - d is shifted into the result register MSB; a_sh and b_sh shift right.
    - cnt++.
  - When cnt == WIDTH-1 on that edge, go to DONE.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - diff = result register; bout = borrow FF; ovf computed from the captured MSBs and diff[MSB].
  - If out_ready, go to IDLE on that edge.
  - Otherwise all outputs hold stable, bit-exact, until accepted.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge.
- Throughput: best case one operation per WIDTH+2 cycles (IDLE, WIDTH x RUN, DONE). Operations never overlap.
- WIDTH == 1: RUN lasts exactly one cycle. The counter is sized max(1, $clog2(WIDTH)) bits.
- Output validity: diff/bout/ovf are defined only while out_valid = 1. Outside DONE they show internal register contents and are don't-care to checkers.
- in_valid while busy: ignored (in_ready = 0). Operands must be held by the source until the handshake.
- out_ready high before DONE: no effect.
- Reset mid-RUN or mid-DONE: the operation is abandoned with no output. The next cycle after reset release shows IDLE with in_ready = 1.
- Arithmetic: all unsigned modulo 2^WIDTH. Identity a - b - bin == a + ~b + ~bin; the verification reference model uses this.

Decomposition:
- Package serial_subtractor_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} ss_state_t
  - function cnt_width(int w) returning max(1, $clog2(w))
- Sub-module full_subtractor: combinational one-bit cell.
  - Ports x, y, bin -> d, bout.
  - Instantiated once for the serial datapath, mirroring how full_adder serves the ripple adder.
- Everything else (FSM, shift registers, counter, ovf) lives in serial_subtractor.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, bin=0 -> after 8 cycles diff=0x23, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0, ovf=0.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Back-pressure: out_ready=0 for 5 cycles in DONE -> out_valid, diff, bout, ovf stable each cycle; in_ready=0 throughout; in_valid pulses ignored.
- Reset: assert rst=0 on the 3rd RUN cycle of a=0xAA, b=0x55 -> no out_valid. One cycle after release in_ready=1; the next op a=0x05, b=0x03 gives diff=0x02.
- WIDTH=1 and WIDTH=3 builds:
  - exhaustive a, b, bin sweep vs the a + ~b + ~bin reference;
  - latency check out_valid exactly WIDTH cycles after accept;
  - back-to-back ops with out_ready=1 spaced WIDTH+2 cycles.
